// File: rtl/char_buffer_write_arbiter.sv
// char_buffer_write_arbiter
//   Owns the single char_buffer write port. Shares it between command_handler
//   single-character writes (strict priority, never delayed) and an internal
//   fill sequencer that writes one character to a run of consecutive cells.
//   Fill addresses wrap modulo BUF_SIZE to follow the circular scroll scheme.
//   All outputs to char_buffer are registered: a write granted in cycle N is
//   presented in cycle N+1.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   cmd_char/address  single-character write from command_handler
//   cmd_wen           single-cycle write request, always granted
//   fill_start        pulse: begin a run (ignored while a run is active)
//   fill_address      first cell of the run (< BUF_SIZE)
//   fill_count        number of cells; 0 = no run, clamped to BUF_SIZE
//   fill_char         character written to every cell of the run
//   fill_abort        terminate the active run
//   fill_busy         a run is in progress
//   fill_done         one-cycle pulse after a run finishes or is aborted
//   new_char*         char_buffer din / waddr / wen
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no run active; only command writes reach the buffer
// ST_FILL | run active; fill writes in every cycle without cmd_wen

module char_buffer_write_arbiter #(
  parameter int ADDR_BITS = 11,
  parameter int BUF_SIZE  = 2000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           cmd_char,
  input  logic [ADDR_BITS-1:0] cmd_address,
  input  logic                 cmd_wen,
  input  logic                 fill_start,
  input  logic [ADDR_BITS-1:0] fill_address,
  input  logic [ADDR_BITS:0]   fill_count,
  input  logic [7:0]           fill_char,
  input  logic                 fill_abort,
  output logic                 fill_busy,
  output logic                 fill_done,
  output logic [7:0]           new_char,
  output logic [ADDR_BITS-1:0] new_char_address,
  output logic                 new_char_wen
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  localparam logic [ADDR_BITS:0]   REMAIN_MAX = (ADDR_BITS+1)'(BUF_SIZE);
  localparam logic [ADDR_BITS:0]   REMAIN_ONE = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0] ADDR_LAST  = ADDR_BITS'(BUF_SIZE - 1);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE   = ADDR_BITS'(1);

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [ADDR_BITS:0]   remain_q, remain_d;
  logic [7:0]           char_q, char_d;
  logic [7:0]           new_char_q, new_char_d;
  logic [ADDR_BITS-1:0] new_char_address_q, new_char_address_d;
  logic                 new_char_wen_q, new_char_wen_d;
  logic                 fill_done_q, fill_done_d;
  logic                 fill_grant;

  always_comb begin
    state_d            = state_q;
    addr_d             = addr_q;
    remain_d           = remain_q;
    char_d             = char_q;
    fill_done_d        = 1'b0;
    fill_grant         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A zero-length start is a no-op: no writes and no done pulse.
        if (fill_start && (fill_count != '0)) begin
          state_d  = ST_FILL;
          addr_d   = fill_address;
          remain_d = (fill_count > REMAIN_MAX) ? REMAIN_MAX : fill_count;
          char_d   = fill_char;
        end
      end
      ST_FILL: begin
        if (fill_abort) begin
          state_d     = ST_IDLE;
          fill_done_d = 1'b1;
        end else if (!cmd_wen) begin
          // cmd_wen steals the port; the run simply stalls that cycle.
          fill_grant = 1'b1;
          addr_d     = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_ONE;
          remain_d   = remain_q - REMAIN_ONE;
          if (remain_q == REMAIN_ONE) begin
            state_d     = ST_IDLE;
            fill_done_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Without a grant the data/address registers hold their last values.
    new_char_wen_d     = cmd_wen | fill_grant;
    new_char_d         = new_char_q;
    new_char_address_d = new_char_address_q;
    if (cmd_wen) begin
      new_char_d         = cmd_char;
      new_char_address_d = cmd_address;
    end else if (fill_grant) begin
      new_char_d         = char_q;
      new_char_address_d = addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= ST_IDLE;
      addr_q             <= '0;
      remain_q           <= '0;
      char_q             <= '0;
      new_char_q         <= '0;
      new_char_address_q <= '0;
      new_char_wen_q     <= 1'b0;
      fill_done_q        <= 1'b0;
    end else begin
      state_q            <= state_d;
      addr_q             <= addr_d;
      remain_q           <= remain_d;
      char_q             <= char_d;
      new_char_q         <= new_char_d;
      new_char_address_q <= new_char_address_d;
      new_char_wen_q     <= new_char_wen_d;
      fill_done_q        <= fill_done_d;
    end
  end

  assign fill_busy        = (state_q == ST_FILL);
  assign fill_done        = fill_done_q;
  assign new_char         = new_char_q;
  assign new_char_address = new_char_address_q;
  assign new_char_wen     = new_char_wen_q;

endmodule

// File: tb/tb_char_buffer_write_arbiter.sv
module tb_char_buffer_write_arbiter;

  localparam int AB = 11;
  localparam int BS = 2000;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    cmd_char;
  logic [AB-1:0] cmd_address;
  logic          cmd_wen;
  logic          fill_start;
  logic [AB-1:0] fill_address;
  logic [AB:0]   fill_count;
  logic [7:0]    fill_char;
  logic          fill_abort;
  logic          fill_busy;
  logic          fill_done;
  logic [7:0]    new_char;
  logic [AB-1:0] new_char_address;
  logic          new_char_wen;

  always #5 clk = ~clk;

  char_buffer_write_arbiter #(.ADDR_BITS(AB), .BUF_SIZE(BS)) dut (
    .clk(clk), .reset(reset),
    .cmd_char(cmd_char), .cmd_address(cmd_address), .cmd_wen(cmd_wen),
    .fill_start(fill_start), .fill_address(fill_address), .fill_count(fill_count),
    .fill_char(fill_char), .fill_abort(fill_abort),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .new_char(new_char), .new_char_address(new_char_address),
    .new_char_wen(new_char_wen)
  );

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  // scoreboard: expected writes {address, char} in order
  logic [AB+7:0] exp_q[$];
  logic [AB+7:0] mon_e;

  // reference model: remaining cells of the active run as an explicit list
  logic [AB-1:0] cells[$];
  logic [7:0]    m_char;
  bit            m_busy = 1'b0;
  bit            m_done = 1'b0;

  always @(negedge clk) begin
    if (new_char_wen === 1'b1) begin
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected got addr=%0d char=%02h required no write",
                 new_char_address, new_char);
      end else begin
        mon_e = exp_q.pop_front();
        if ({new_char_address, new_char} !== mon_e) begin
          errors++;
          $display("FAIL write_data got addr=%0d char=%02h required addr=%0d char=%02h",
                   new_char_address, new_char, mon_e[AB+7:8], mon_e[7:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  task automatic model_step();
    logic [AB-1:0] a;
    int n;
    m_done = 1'b0;
    if (reset) begin
      cells.delete();
      m_busy = 1'b0;
      return;
    end
    if (cmd_wen) exp_q.push_back({cmd_address, cmd_char});
    if (m_busy) begin
      if (fill_abort) begin
        cells.delete();
        m_busy = 1'b0;
        m_done = 1'b1;
      end else if (!cmd_wen) begin
        a = cells.pop_front();
        exp_q.push_back({a, m_char});
        if (cells.size() == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end else if (fill_start && fill_count != 0) begin
      n = (int'(fill_count) > BS) ? BS : int'(fill_count);
      for (int i = 0; i < n; i++) cells.push_back(AB'((int'(fill_address) + i) % BS));
      m_char = fill_char;
      m_busy = 1'b1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("fill_busy", int'(fill_busy), int'(m_busy));
    chk("fill_done", int'(fill_done), int'(m_done));
    if (fill_busy) busy_cnt++;
    if (fill_done) done_cnt++;
  endtask

  task automatic clear_inputs();
    cmd_wen = 0; fill_start = 0; fill_abort = 0; reset = 0;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_fill(input int addr, input int cnt, input logic [7:0] ch);
    clear_inputs();
    fill_start = 1; fill_address = AB'(addr); fill_count = (AB+1)'(cnt); fill_char = ch;
    tick();
    fill_start = 0;
  endtask

  task automatic reset_counters();
    wr_count = 0; busy_cnt = 0; done_cnt = 0;
  endtask

  initial begin
    int w0;
    reset = 1; cmd_char = 0; cmd_address = 0; cmd_wen = 0;
    fill_start = 0; fill_address = 0; fill_count = 0; fill_char = 0; fill_abort = 0;
    tick(); tick();
    chk("reset_wen", int'(new_char_wen), 0);
    chk("reset_char", int'(new_char), 0);
    chk("reset_addr", int'(new_char_address), 0);
    idle(2);

    // 1: single command write in IDLE
    reset_counters();
    cmd_wen = 1; cmd_address = 5; cmd_char = 8'h41;
    tick();
    idle(3);
    chk("t1_writes", wr_count, 1);
    chk("t1_busy", busy_cnt, 0);

    // 2: wrapping fill
    reset_counters();
    start_fill(1990, 20, 8'h20);
    idle(24);
    chk("t2_writes", wr_count, 20);
    chk("t2_busy_cycles", busy_cnt, 20);
    chk("t2_done_pulses", done_cnt, 1);

    // 3: cmd write stalls the run in its second FILL cycle
    reset_counters();
    start_fill(100, 4, 8'h2e);
    tick();
    cmd_wen = 1; cmd_address = 7; cmd_char = 8'h58;
    tick();
    idle(6);
    chk("t3_writes", wr_count, 5);
    chk("t3_busy_cycles", busy_cnt, 5);

    // 4: zero-length start, then oversized run clamped to the buffer
    reset_counters();
    start_fill(300, 0, 8'h11);
    idle(4);
    chk("t4_zero_writes", wr_count, 0);
    chk("t4_zero_done", done_cnt, 0);
    start_fill(0, 4095, 8'h00);
    idle(2010);
    chk("t4_full_writes", wr_count, 2000);
    chk("t4_full_done", done_cnt, 1);

    // 5: abort after 3 writes; restart while busy is ignored
    reset_counters();
    start_fill(500, 10, 8'h33);
    tick();
    fill_start = 1; fill_address = 900; fill_count = 5; fill_char = 8'h77;
    tick();
    fill_start = 0;
    tick();
    fill_abort = 1;
    tick();
    idle(5);
    chk("t5_writes", wr_count, 3);
    chk("t5_done_pulses", done_cnt, 1);

    // start and abort together in IDLE: start wins
    reset_counters();
    fill_start = 1; fill_abort = 1; fill_address = 1998; fill_count = 3; fill_char = 8'h44;
    tick();
    idle(5);
    chk("t5b_writes", wr_count, 3);

    // 6: reset mid-run
    reset_counters();
    start_fill(40, 50, 8'h55);
    idle(10);
    reset = 1;
    tick();
    chk("t6_reset_wen", int'(new_char_wen), 0);
    chk("t6_reset_addr", int'(new_char_address), 0);
    chk("t6_reset_char", int'(new_char), 0);
    w0 = wr_count;
    done_cnt = 0;
    idle(60);
    chk("t6_writes_after_reset", wr_count - w0, 0);
    chk("t6_done_after_reset", done_cnt, 0);
    reset_counters();
    start_fill(1999, 3, 8'h66);
    idle(5);
    chk("t6_new_run_writes", wr_count, 3);

    // randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      reset        = ($urandom_range(0, 499) == 0);
      cmd_wen      = ($urandom_range(0, 5) == 0);
      cmd_address  = AB'($urandom_range(0, BS-1));
      cmd_char     = 8'($urandom);
      fill_start   = ($urandom_range(0, 14) == 0);
      fill_address = AB'($urandom_range(0, BS-1));
      case ($urandom_range(0, 9))
        0:       fill_count = 0;
        1:       fill_count = (AB+1)'($urandom_range(1990, 4095));
        default: fill_count = (AB+1)'($urandom_range(1, 40));
      endcase
      fill_char    = 8'($urandom);
      fill_abort   = ($urandom_range(0, 39) == 0);
      tick();
    end
    clear_inputs();
    for (int i = 0; i < 2100 && m_busy; i++) tick();
    idle(3);
    chk("final_model_idle", int'(m_busy), 0);
    chk("final_scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
